// File: rtl/decode_stage_pkg.sv
// Shared definitions for the Atom decode stage: opcodes, control codes,
// immediate formats and the execute-stage control bundle.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int unsigned REG_SEL_W   = 5;
    localparam int unsigned CMP_W       = 3;
    localparam int unsigned ALU_W       = 3;
    localparam int unsigned RF_DIN_W    = 3;
    localparam int unsigned MULDIV_OP_W = 3;
    localparam int unsigned MEM_WIDTH_W = 3;

    // Branch codes equal the branch func3; the unused 010 slot means "always taken".
    typedef enum logic [CMP_W-1:0] {
        CMP_EQ  = 3'b000,
        CMP_NQ  = 3'b001,
        CMP_UN  = 3'b010,
        CMP_LT  = 3'b100,
        CMP_GE  = 3'b101,
        CMP_LTU = 3'b110,
        CMP_GEU = 3'b111
    } cmp_e;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    localparam logic [RF_DIN_W-1:0] RF_DIN_IMM    = 3'd0;
    localparam logic [RF_DIN_W-1:0] RF_DIN_PC4    = 3'd1;
    localparam logic [RF_DIN_W-1:0] RF_DIN_ALU    = 3'd2;
    localparam logic [RF_DIN_W-1:0] RF_DIN_CMP    = 3'd3;
    localparam logic [RF_DIN_W-1:0] RF_DIN_MEM    = 3'd4;
    localparam logic [RF_DIN_W-1:0] RF_DIN_MULDIV = 3'd5;

    typedef struct packed {
        logic [REG_SEL_W-1:0]   rd_sel;
        logic [REG_SEL_W-1:0]   rs1_sel;
        logic [REG_SEL_W-1:0]   rs2_sel;
        logic [31:0]            imm;
        logic                   jump_en;
        cmp_e                   comparison_type;
        logic                   cmp_b_op_sel;
        logic                   rf_we;
        logic [RF_DIN_W-1:0]    rf_din_sel;
        logic                   a_op_sel;
        logic                   b_op_sel;
        alu_e                   alu_op_sel;
        logic                   muldiv_en;
        logic [MULDIV_OP_W-1:0] muldiv_op;
        logic [MEM_WIDTH_W-1:0] mem_access_width;
        logic                   mem_load_store;
        logic                   mem_we;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        rd_sel: 5'd0, rs1_sel: 5'd0, rs2_sel: 5'd0, imm: 32'd0,
        jump_en: 1'b0, comparison_type: CMP_UN, cmp_b_op_sel: 1'b0,
        rf_we: 1'b0, rf_din_sel: RF_DIN_IMM, a_op_sel: 1'b0, b_op_sel: 1'b0,
        alu_op_sel: ALU_ADD, muldiv_en: 1'b0, muldiv_op: 3'd0,
        mem_access_width: 3'd0, mem_load_store: 1'b0, mem_we: 1'b0
    };

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   gen_imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   gen_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   gen_imm = {instr[31:12], 12'h000};
            IMM_J:   gen_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: gen_imm = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I(+M, +E) decoder producing the execute control bundle
// and an illegal-instruction flag.
module instr_decoder
    import decode_stage_pkg::*;
#(
    parameter bit RV32E = 1'b0,
    parameter bit EN_M  = 1'b0
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [6:0] opcode_s;
    logic [2:0] func3_s;
    logic [6:0] func7_s;
    imm_fmt_e   fmt_s;
    ctrl_t      ctrl_s;
    logic       bad_s;
    logic       arith_s;
    logic       is_op_s;
    logic       use_rd_s;
    logic       use_rs1_s;
    logic       use_rs2_s;

    assign opcode_s = instr_i[6:0];
    assign func3_s  = instr_i[14:12];
    assign func7_s  = instr_i[31:25];

    // Opcode decode, arithmetic sub-decode, legality and illegal squashing.
    always_comb begin
        ctrl_s                 = CTRL_RESET;
        ctrl_s.rd_sel          = instr_i[11:7];
        ctrl_s.rs1_sel         = instr_i[19:15];
        ctrl_s.rs2_sel         = instr_i[24:20];
        fmt_s                  = IMM_NONE;
        bad_s                  = 1'b0;
        arith_s                = 1'b0;
        is_op_s                = 1'b0;
        use_rd_s               = 1'b0;
        use_rs1_s              = 1'b0;
        use_rs2_s              = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                fmt_s = IMM_U; ctrl_s.rf_we = 1'b1; ctrl_s.rf_din_sel = RF_DIN_IMM;
                use_rd_s = 1'b1;
            end
            OPC_AUIPC: begin
                fmt_s = IMM_U; ctrl_s.rf_we = 1'b1; ctrl_s.rf_din_sel = RF_DIN_ALU;
                ctrl_s.a_op_sel = 1'b1; ctrl_s.b_op_sel = 1'b1; use_rd_s = 1'b1;
            end
            OPC_JAL: begin
                fmt_s = IMM_J; ctrl_s.rf_we = 1'b1; ctrl_s.rf_din_sel = RF_DIN_PC4;
                ctrl_s.jump_en = 1'b1; ctrl_s.a_op_sel = 1'b1; ctrl_s.b_op_sel = 1'b1;
                use_rd_s = 1'b1;
            end
            OPC_JALR: begin
                fmt_s = IMM_I; ctrl_s.rf_we = 1'b1; ctrl_s.rf_din_sel = RF_DIN_PC4;
                ctrl_s.jump_en = 1'b1; ctrl_s.b_op_sel = 1'b1;
                use_rd_s = 1'b1; use_rs1_s = 1'b1;
                bad_s = (func3_s != 3'b000);
            end
            OPC_BRANCH: begin
                fmt_s = IMM_B; ctrl_s.jump_en = 1'b1; ctrl_s.comparison_type = cmp_e'(func3_s);
                ctrl_s.a_op_sel = 1'b1; ctrl_s.b_op_sel = 1'b1;
                use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                bad_s = (func3_s[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                fmt_s = IMM_I; ctrl_s.rf_we = 1'b1; ctrl_s.rf_din_sel = RF_DIN_MEM;
                ctrl_s.mem_load_store = 1'b1; ctrl_s.b_op_sel = 1'b1;
                ctrl_s.mem_access_width = func3_s; use_rd_s = 1'b1; use_rs1_s = 1'b1;
                bad_s = (func3_s == 3'b011) || (func3_s[2:1] == 2'b11);
            end
            OPC_STORE: begin
                fmt_s = IMM_S; ctrl_s.mem_load_store = 1'b1; ctrl_s.mem_we = 1'b1;
                ctrl_s.b_op_sel = 1'b1; ctrl_s.mem_access_width = func3_s;
                use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                bad_s = (func3_s >= 3'b011);
            end
            OPC_OP_IMM: begin
                fmt_s = IMM_I; arith_s = 1'b1; ctrl_s.rf_we = 1'b1;
                ctrl_s.b_op_sel = 1'b1; ctrl_s.cmp_b_op_sel = 1'b1;
                use_rd_s = 1'b1; use_rs1_s = 1'b1;
                bad_s = ((func3_s == 3'b001) && (func7_s != 7'b0000000)) ||
                        ((func3_s == 3'b101) && (func7_s != 7'b0000000) && (func7_s != 7'b0100000));
            end
            OPC_OP: begin
                use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                if (func7_s == 7'b0000001) begin
                    if (EN_M) begin
                        ctrl_s.muldiv_en = 1'b1; ctrl_s.rf_we = 1'b1;
                        ctrl_s.rf_din_sel = RF_DIN_MULDIV; ctrl_s.muldiv_op = func3_s;
                    end else begin
                        bad_s = 1'b1;
                    end
                end else begin
                    arith_s = 1'b1; is_op_s = 1'b1; ctrl_s.rf_we = 1'b1;
                    bad_s = !((func7_s == 7'b0000000) ||
                              ((func7_s == 7'b0100000) && ((func3_s == 3'b000) || (func3_s == 3'b101))));
                end
            end
            OPC_FENCE: begin
                bad_s = 1'b0;
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase

        if (arith_s) begin
            ctrl_s.rf_din_sel = RF_DIN_ALU;
            case (func3_s)
                3'b000:  ctrl_s.alu_op_sel = (is_op_s && func7_s[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  ctrl_s.alu_op_sel = ALU_SLL;
                3'b010:  begin ctrl_s.rf_din_sel = RF_DIN_CMP; ctrl_s.comparison_type = CMP_LT;  end
                3'b011:  begin ctrl_s.rf_din_sel = RF_DIN_CMP; ctrl_s.comparison_type = CMP_LTU; end
                3'b100:  ctrl_s.alu_op_sel = ALU_XOR;
                3'b101:  ctrl_s.alu_op_sel = func7_s[5] ? ALU_SRA : ALU_SRL;
                3'b110:  ctrl_s.alu_op_sel = ALU_OR;
                default: ctrl_s.alu_op_sel = ALU_AND;
            endcase
        end else begin
            ctrl_s.cmp_b_op_sel = ctrl_s.cmp_b_op_sel;
        end

        // RV32E exposes only x0..x15, so bit 4 of any used index is illegal.
        bad_s = bad_s | (RV32E & ((use_rd_s & instr_i[11]) | (use_rs1_s & instr_i[19]) |
                                  (use_rs2_s & instr_i[24])));
        ctrl_s.imm = gen_imm(instr_i, fmt_s);

        if (bad_s) begin
            ctrl_s.rf_we          = 1'b0;
            ctrl_s.jump_en        = 1'b0;
            ctrl_s.mem_we         = 1'b0;
            ctrl_s.mem_load_store = 1'b0;
            ctrl_s.muldiv_en      = 1'b0;
        end else begin
            ctrl_s.rf_we          = ctrl_s.rf_we;
        end
    end

    assign ctrl_o    = ctrl_s;
    assign illegal_o = bad_s;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: instr_decoder followed by a single output register
// with valid/ready handshake, flush and synchronous reset.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit RV32E = 1'b0,
    parameter bit EN_M  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] pc_o,
    output logic [4:0]  rd_sel_o,
    output logic [4:0]  rs1_sel_o,
    output logic [4:0]  rs2_sel_o,
    output logic [31:0] imm_o,
    output logic        jump_en_o,
    output logic [2:0]  comparison_type_o,
    output logic        cmp_b_op_sel_o,
    output logic        rf_we_o,
    output logic [2:0]  rf_din_sel_o,
    output logic        a_op_sel_o,
    output logic        b_op_sel_o,
    output logic [2:0]  alu_op_sel_o,
    output logic        muldiv_en_o,
    output logic [2:0]  muldiv_op_o,
    output logic [2:0]  mem_access_width_o,
    output logic        mem_load_store_o,
    output logic        mem_we_o,
    output logic        illegal_o
);

    ctrl_t       dec_ctrl_s;
    logic        dec_illegal_s;
    logic        accept_s;
    logic        valid_d, valid_q;
    ctrl_t       ctrl_d, ctrl_q;
    logic [31:0] pc_d, pc_q;
    logic        illegal_d, illegal_q;

    instr_decoder #(.RV32E(RV32E), .EN_M(EN_M)) u_instr_decoder (
        .instr_i   (instr_i),
        .ctrl_o    (dec_ctrl_s),
        .illegal_o (dec_illegal_s)
    );

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept_s   = in_valid_i && in_ready_o;

    // Next state: flush beats accept; data only loads on accept.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d   = 1'b1;
            ctrl_d    = dec_ctrl_s;
            pc_d      = pc_i;
            illegal_d = dec_illegal_s;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_RESET;
            pc_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid_o        = valid_q;
    assign pc_o               = pc_q;
    assign rd_sel_o           = ctrl_q.rd_sel;
    assign rs1_sel_o          = ctrl_q.rs1_sel;
    assign rs2_sel_o          = ctrl_q.rs2_sel;
    assign imm_o              = ctrl_q.imm;
    assign jump_en_o          = ctrl_q.jump_en;
    assign comparison_type_o  = ctrl_q.comparison_type;
    assign cmp_b_op_sel_o     = ctrl_q.cmp_b_op_sel;
    assign rf_we_o            = ctrl_q.rf_we;
    assign rf_din_sel_o       = ctrl_q.rf_din_sel;
    assign a_op_sel_o         = ctrl_q.a_op_sel;
    assign b_op_sel_o         = ctrl_q.b_op_sel;
    assign alu_op_sel_o       = ctrl_q.alu_op_sel;
    assign muldiv_en_o        = ctrl_q.muldiv_en;
    assign muldiv_op_o        = ctrl_q.muldiv_op;
    assign mem_access_width_o = ctrl_q.mem_access_width;
    assign mem_load_store_o   = ctrl_q.mem_load_store;
    assign mem_we_o           = ctrl_q.mem_we;
    assign illegal_o          = illegal_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32 decode stage between fetch and execute in the Atom core. Decodes one instruction per cycle into the execute-stage control bundle and holds it in an output register behind a valid/ready handshake. Adds three things the combinational decoder lacks: flush, illegal-instruction detection, and configurable RV32E / M-extension support.

## Interface
- `RV32E`, default 0: 1 makes any used register index ≥16 illegal.
- `EN_M`, default 0: 1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 makes them illegal.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: discard held and incoming instruction.
- `in_valid_i` in 1, `in_ready_o` out 1: fetch-side handshake.
- `instr_i` in 32, `pc_i` in 32: instruction word and its address.
- `out_valid_o` out 1, `out_ready_i` in 1: execute-side handshake.
- `pc_o` out 32: registered `pc_i`.
- `rd_sel_o`, `rs1_sel_o`, `rs2_sel_o` out 5 each: instr[11:7], [19:15], [24:20].
- `imm_o` out 32: sign-extended immediate.
- `jump_en_o` out 1; `comparison_type_o` out 3; `cmp_b_op_sel_o` out 1.
- `rf_we_o` out 1; `rf_din_sel_o` out 3. Codes: 0 imm, 1 pc+4, 2 alu, 3 cmp, 4 mem, 5 muldiv.
- `a_op_sel_o`, `b_op_sel_o` out 1 each; `alu_op_sel_o` out 3.
- `muldiv_en_o` out 1; `muldiv_op_o` out 3 (func3).
- `mem_access_width_o` out 3 (func3); `mem_load_store_o` out 1; `mem_we_o` out 1.
- `illegal_o` out 1: decoded instruction is illegal or SYSTEM.

## Operation
- Decoding of LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM and OP matches the existing Atom control encoding. Immediate formats are I/S/B/U/J.
- FENCE (0001111) decodes as a legal NOP: all enables are 0.
- MUL/DIV group (func7=0000001, opcode 0110011) with `EN_M`=1: `muldiv_en_o`=1, `rf_we_o`=1, `rf_din_sel_o`=5.
- Illegal conditions (`illegal_o`=1):
  - unknown opcode;
  - func7 not 0000000 on OP / shift-immediate encodings, except SUB/SRA/SRAI with 0100000;
  - JALR func3≠0;
  - branch func3 010 or 011;
  - load func3 011, 110 or 111;
  - store func3 ≥011;
  - M instruction with `EN_M`=0;
  - SYSTEM opcode (1110011);
  - `RV32E`=1 and a used register index ≥16 (rd, rs1, or rs2 where the format uses it).
- When `illegal_o`=1, force `rf_we_o`, `jump_en_o`, `mem_we_o`, `mem_load_store_o` and `muldiv_en_o` to 0. The instruction is still delivered with `out_valid_o`=1.

## Timing
- Single stage, latency 1: instruction accepted at edge N appears on the outputs after edge N.
- `in_ready_o` = !`out_valid_o` || `out_ready_i`, combinational. Full throughput when `out_ready_i`=1.
- Accept occurs when `in_valid_i` && `in_ready_o`; the output register loads and `out_valid_o`=1.
- Output transfers when `out_valid_o` && `out_ready_i`. With no accept in the same cycle, `out_valid_o` falls to 0.
- Stall (`out_valid_o`=1, `out_ready_i`=0): every output holds bit-stable.
- `flush_i`=1: next cycle `out_valid_o`=0. Any same-cycle input is dropped. Flush wins over accept.
- Reset forces the same state as flush, plus all data/control registers to 0, `comparison_type_o`=CMP_UN and `alu_op_sel_o`=ALU_ADD. Reset mid-stall discards the held instruction.
- Output register updates only on accept, so data is unchanged while `out_valid_o`=0.

## Structure
- Shared header/package holds: opcode constants; CMP_* and ALU_* codes; immediate-format codes; RF_DIN_* select codes; control-bundle field widths.
- Sub-module `instr_decoder` is purely combinational: instruction in, control bundle + `illegal` out, parametrised by `RV32E` and `EN_M`.
- `decode_stage` holds the handshake logic and the output register.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with `out_ready_i`=1 → next cycle: `out_valid_o`=1, rd=1, rs1=0, `imm_o`=5, `rf_we_o`=1, `rf_din_sel_o`=2, `b_op_sel_o`=1, ALU_ADD.
- BNE x1,x2,-4 (0xFE209EE3) → `imm_o`=0xFFFFFFFC, `jump_en_o`=1, `comparison_type_o`=CMP_NQ, `rf_we_o`=0.
- `out_ready_i`=0 while sending 0x00500093 then 0x00208833 → first instruction held stable and `in_ready_o`=0; raise ready → both delivered once, in order, no duplication.
- MUL x3,x1,x2 (0x022081B3):
  - `EN_M`=1 → `muldiv_en_o`=1, `muldiv_op_o`=0, `rf_din_sel_o`=5.
  - `EN_M`=0 → `illegal_o`=1, `rf_we_o`=0.
- ADD x16,x1,x2 (0x00208833):
  - `RV32E`=1 → `illegal_o`=1, `rf_we_o`=0.
  - `RV32E`=0 → legal, rd=16.
- Stalled valid output plus `flush_i`=1 with `in_valid_i`=1 → next cycle `out_valid_o`=0 and the input is not delivered. Repeat with `rst_i` instead → same result, all outputs at reset values.
